// File: rtl/bubble_sort_engine_if.sv
// rtl/bubble_sort_engine_if.sv - host-side bus bundle for bubble_sort_engine
//
// Purpose: groups the write port, read port, sort control and status
// signals of the sort engine. The host drives the master modport; the
// engine uses the slave modport.
// Signals:
//   wr_en/wr_addr/wr_data  array write port (honoured only when idle)
//   rd_addr/rd_data        array read port, rd_data registered (1 cycle)
//   start/len/desc         sort request, element count, order select
//   busy/done              compare phase active / one-cycle completion
//   swap_cnt               swaps performed by the last sort
interface bubble_sort_engine_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int AW     = $clog2(DEPTH),
  parameter int LW     = $clog2(DEPTH + 1)
);
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [AW-1:0]     rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              start;
  logic [LW-1:0]     len;
  logic              desc;
  logic              busy;
  logic              done;
  logic [15:0]       swap_cnt;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr, start, len, desc,
    input  rd_data, busy, done, swap_cnt
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr, start, len, desc,
    output rd_data, busy, done, swap_cnt
  );
endinterface

// File: rtl/bubble_sort_engine.sv
// rtl/bubble_sort_engine.sv - in-place bubble sort engine, one compare-and-swap per clock
//
// Purpose: holds a DEPTH-entry array of DATA_W-bit unsigned words and sorts
// entries [0, len) ascending or descending. Each pass shrinks its upper bound
// by one and the sort ends early after a pass with no swap.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (clears FSM, array, outputs)
//   bus    bubble_sort_engine_if.slave: write/read ports, start/len/desc,
//          busy/done status and swap_cnt
// Optional feature: define SORT_STATS_EN to build the saturating swap
// counter; otherwise swap_cnt is tied to 0. Sort timing is the same.
module bubble_sort_engine #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int AW     = $clog2(DEPTH),
  parameter int LW     = $clog2(DEPTH + 1)
) (
  input logic                 clk,
  input logic                 rst_n,
  bubble_sort_engine_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PASS,
    S_DONE
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     idx;
  logic [LW-1:0]     bound;
  logic              swapped;
  logic              desc_q;
  logic              busy_q;
  logic              done_q;
  logic [DATA_W-1:0] rd_q;

  logic [AW-1:0]     idx_nxt;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              out_of_order;
  logic              swap_now;
  logic              last;
  logic              start_acc;
  logic [LW-1:0]     len_clamp;
  logic              wr_ok;
  logic              rd_ok;

  always_comb begin
    idx_nxt      = idx + AW'(1);
    a            = mem[idx];
    b            = mem[idx_nxt];
    // Strict comparison: equal keys stay put, keeping the sort stable.
    out_of_order = desc_q ? (a < b) : (a > b);
    swap_now     = (state == S_PASS) && out_of_order;
    // bound counts compares in the current pass, so the last pair sits at bound-1.
    last         = (LW'(idx) == (bound - LW'(1)));
    start_acc    = (state == S_IDLE) && bus.start;
    len_clamp    = (bus.len > LW'(DEPTH)) ? LW'(DEPTH) : bus.len;
    // Address guards only matter when DEPTH is not a power of two.
    wr_ok        = (32'(bus.wr_addr) < 32'(DEPTH));
    rd_ok        = (32'(bus.rd_addr) < 32'(DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      idx     <= '0;
      bound   <= '0;
      swapped <= 1'b0;
      desc_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      // Non-blocking read returns the pre-edge contents, even mid-swap.
      rd_q   <= rd_ok ? mem[bus.rd_addr] : '0;
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          // A write in the start cycle lands at this same edge, so the
          // first compare already sees it.
          if (bus.wr_en && wr_ok) mem[bus.wr_addr] <= bus.wr_data;
          if (start_acc) begin
            desc_q  <= bus.desc;
            idx     <= '0;
            swapped <= 1'b0;
            bound   <= len_clamp - LW'(1);
            if (len_clamp <= LW'(1)) begin
              state  <= S_DONE;
              done_q <= 1'b1;
            end else begin
              state  <= S_PASS;
              busy_q <= 1'b1;
            end
          end
        end
        S_PASS: begin
          if (swap_now) begin
            mem[idx]     <= b;
            mem[idx_nxt] <= a;
          end
          if (!last) begin
            idx     <= idx_nxt;
            swapped <= swapped | swap_now;
          end else if ((swapped || swap_now) && (bound > LW'(1))) begin
            bound   <= bound - LW'(1);
            idx     <= '0;
            swapped <= 1'b0;
          end else begin
            state  <= S_DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef SORT_STATS_EN
  logic [15:0] swap_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      swap_cnt_q <= '0;
    end else if (start_acc) begin
      swap_cnt_q <= '0;
    end else if (swap_now && (swap_cnt_q != 16'hFFFF)) begin
      swap_cnt_q <= swap_cnt_q + 16'd1;
    end
  end

  assign bus.swap_cnt = swap_cnt_q;
`else
  assign bus.swap_cnt = 16'd0;
`endif

  assign bus.rd_data = rd_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_bubble_sort_engine.sv
// tb/tb_bubble_sort_engine.sv - directed self-checking bench for bubble_sort_engine
module tb_bubble_sort_engine;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 8;
  localparam int AW     = $clog2(DEPTH);
  localparam int LW     = $clog2(DEPTH + 1);
`ifdef SORT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  bubble_sort_engine_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  bubble_sort_engine #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int addr, input logic [DATA_W-1:0] data);
    bus.wr_en   = 1'b1;
    bus.wr_addr = AW'(addr);
    bus.wr_data = data;
    step();
    bus.wr_en = 1'b0;
  endtask

  task automatic rd(input int addr, output logic [DATA_W-1:0] data);
    bus.rd_addr = AW'(addr);
    step();
    data = bus.rd_data;
  endtask

  // Pulses start, returns busy after the start edge and the number of edges
  // from the start edge until done is seen.
  task automatic run_sort(input int l, input logic d, output int cyc, output logic busy_k);
    bus.start = 1'b1;
    bus.len   = LW'(l);
    bus.desc  = d;
    step();
    bus.start = 1'b0;
    busy_k = bus.busy;
    cyc = 0;
    while (!bus.done && cyc < 200) begin
      step();
      cyc++;
    end
  endtask

  task automatic wait_done(inout int cyc);
    while (!bus.done && cyc < 200) begin
      step();
      cyc++;
    end
  endtask

  logic [DATA_W-1:0] v;
  int                cyc;
  logic              bk;

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.rd_addr = '0;
    bus.start = 1'b0; bus.len = '0; bus.desc = 1'b0;
    step(); step();
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_swap_cnt", 32'(bus.swap_cnt), 0);
    check("rst_rd_data", 32'(bus.rd_data), 0);
    rst_n = 1'b1;
    step();

    // {9,6,2,4} ascending: 6 compares, 5 swaps.
    wr(0, 9); wr(1, 6); wr(2, 2); wr(3, 4);
    run_sort(4, 1'b0, cyc, bk);
    check("t1_busy_after_start", 32'(bk), 1);
    check("t1_cycles", cyc, 6);
    check("t1_busy_at_done", 32'(bus.busy), 0);
    check("t1_swap_cnt", 32'(bus.swap_cnt), STATS ? 5 : 0);
    step();
    check("t1_done_one_pulse", 32'(bus.done), 0);
    rd(0, v); check("t1_m0", 32'(v), 2);
    rd(1, v); check("t1_m1", 32'(v), 4);
    rd(2, v); check("t1_m2", 32'(v), 6);
    rd(3, v); check("t1_m3", 32'(v), 9);
    check("t1_swap_cnt_hold", 32'(bus.swap_cnt), STATS ? 5 : 0);

    // Already sorted: single pass of 7 compares, no swaps.
    for (int i = 0; i < 8; i++) wr(i, DATA_W'(i + 1));
    run_sort(8, 1'b0, cyc, bk);
    check("t2_cycles", cyc, 7);
    check("t2_swap_cnt", 32'(bus.swap_cnt), 0);
    step();
    rd(0, v); check("t2_m0", 32'(v), 1);
    rd(7, v); check("t2_m7", 32'(v), 8);

    // {3,1,5,1} descending, index 4 must stay 0xAA.
    wr(0, 3); wr(1, 1); wr(2, 5); wr(3, 1); wr(4, 16'h00AA);
    run_sort(4, 1'b1, cyc, bk);
    check("t3_cycles", cyc, 6);
    check("t3_swap_cnt", 32'(bus.swap_cnt), STATS ? 2 : 0);
    step();
    rd(0, v); check("t3_m0", 32'(v), 5);
    rd(1, v); check("t3_m1", 32'(v), 3);
    rd(2, v); check("t3_m2", 32'(v), 1);
    rd(3, v); check("t3_m3", 32'(v), 1);
    rd(4, v); check("t3_m4_untouched", 32'(v), 16'h00AA);

    // len = 0 and len = 1: immediate done, no busy, array unchanged.
    wr(0, 16'h0077); wr(1, 16'h0011);
    run_sort(0, 1'b0, cyc, bk);
    check("t4_len0_cycles", cyc, 0);
    check("t4_len0_busy", 32'(bk), 0);
    check("t4_len0_done", 32'(bus.done), 1);
    step();
    run_sort(1, 1'b0, cyc, bk);
    check("t4_len1_cycles", cyc, 0);
    check("t4_len1_busy", 32'(bk), 0);
    step();
    rd(0, v); check("t4_m0", 32'(v), 16'h0077);
    rd(1, v); check("t4_m1", 32'(v), 16'h0011);

    // len = DEPTH+5 clamps to DEPTH; whole array sorted.
    wr(0, 7); wr(1, 0); wr(2, 5); wr(3, 2); wr(4, 6); wr(5, 1); wr(6, 3); wr(7, 4);
    run_sort(DEPTH + 5, 1'b0, cyc, bk);
    check("t5_done", 32'(bus.done), 1);
    step();
    for (int i = 0; i < 8; i++) begin
      rd(i, v);
      check($sformatf("t5_m%0d", i), 32'(v), i);
    end

    // Write and start during busy are ignored: {4,3,2,1} -> {1,2,3,4}, 6 compares.
    wr(0, 4); wr(1, 3); wr(2, 2); wr(3, 1);
    bus.start = 1'b1; bus.len = LW'(4); bus.desc = 1'b0;
    step();
    bus.start = 1'b0;
    step();
    bus.wr_en = 1'b1; bus.wr_addr = '0; bus.wr_data = 16'hFFFF;
    bus.start = 1'b1; bus.len = LW'(2); bus.desc = 1'b1;
    step();
    bus.wr_en = 1'b0; bus.start = 1'b0;
    cyc = 2;
    wait_done(cyc);
    check("t6_cycles", cyc, 6);
    check("t6_swap_cnt", 32'(bus.swap_cnt), STATS ? 6 : 0);
    step();
    rd(0, v); check("t6_m0", 32'(v), 1);
    rd(1, v); check("t6_m1", 32'(v), 2);
    rd(2, v); check("t6_m2", 32'(v), 3);
    rd(3, v); check("t6_m3", 32'(v), 4);

    // Reset mid-pass.
    for (int i = 0; i < 8; i++) wr(i, DATA_W'(8 - i));
    bus.rd_addr = AW'(3);
    bus.start = 1'b1; bus.len = LW'(8); bus.desc = 1'b0;
    step();
    bus.start = 1'b0;
    step(); step(); step();
    check("t7_busy_before_rst", 32'(bus.busy), 1);
    rst_n = 1'b0;
    #1;
    check("t7_rst_busy", 32'(bus.busy), 0);
    check("t7_rst_done", 32'(bus.done), 0);
    check("t7_rst_swap_cnt", 32'(bus.swap_cnt), 0);
    check("t7_rst_rd_data", 32'(bus.rd_data), 0);
    step();
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 8; i++) begin
      rd(i, v);
      check($sformatf("t7_zero_m%0d", i), 32'(v), 0);
    end
    wr(0, 9); wr(1, 6); wr(2, 2); wr(3, 4);
    run_sort(4, 1'b0, cyc, bk);
    check("t7_resort_cycles", cyc, 6);
    step();
    rd(0, v); check("t7_m0", 32'(v), 2);
    rd(1, v); check("t7_m1", 32'(v), 4);
    rd(2, v); check("t7_m2", 32'(v), 6);
    rd(3, v); check("t7_m3", 32'(v), 9);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bubble_sort_engine.md
# bubble_sort_engine

Parametrised hardware sort engine that holds a DEPTH-entry array of DATA_W-bit words and sorts the first `len` entries in place by bubble sort, one compare-and-swap per clock. It replaces the software bubble-sort loop on the scalar core. The core loads the array through a write port, pulses `start`, waits for `done`, then reads the results back. It adds configurable width and depth, ascending/descending order, a per-pass shrinking bound and early exit when a pass makes no swap.

## Interface
- DATA_W, 32: element width in bits; compare is unsigned.
- DEPTH, 32: array entries; must be ≥2.
- AW, $clog2(DEPTH): address width.
- LW, $clog2(DEPTH+1): length field width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  write strobe; honoured only in IDLE.
- wr_addr  in  AW  write address.
- wr_data  in  DATA_W  write data.
- rd_addr  in  AW  read address.
- rd_data  out  DATA_W  registered read data: mem[rd_addr] as it was before the edge.
- start  in  1  sort request; honoured only in IDLE.
- len  in  LW  number of elements to sort, from index 0; latched at start; values >DEPTH are clamped to DEPTH.
- desc  in  1  1 = descending, 0 = ascending; latched at start.
- busy  out  1  high while comparing.
- done  out  1  one-cycle completion pulse.
- swap_cnt  out  16  swaps performed in the last sort (see Configuration).

## Operation
- States:
  - IDLE: accepts writes and start.
  - PASS: one compare per cycle.
  - DONE: one cycle, then IDLE.
- Start sampled in IDLE:
  - latch len_q = min(len, DEPTH) and desc_q; clear swap_cnt.
  - If len_q ≤ 1, go to DONE.
  - Otherwise set bound = len_q−1, idx = 0, swapped = 0, and go to PASS.
- PASS, each cycle:
  - Compare a = mem[idx], b = mem[idx+1].
  - Out of order means a > b (asc) or a < b (desc), strictly, so equal keys never swap and the sort is stable.
  - If out of order: exchange the two words, set swapped, increment swap_cnt (saturating at 16'hFFFF).
  - If idx ≠ bound−1: idx++.
  - If idx = bound−1, the pass ends. Let swapped_now = swapped OR this cycle's swap.
    - swapped_now = 1 and bound > 1: bound−−, idx = 0, swapped = 0.
    - Otherwise: go to DONE.
- DONE: done = 1, busy = 0, then IDLE.
- Writes while busy or in DONE are dropped. Start while not in IDLE is ignored. Start and wr_en in the same IDLE cycle: the write lands first, then the sort begins on the updated array.
- rd_addr may be used at any time; during a sort it returns in-flight contents.
- Reset (any time, including mid-sort):
  - state IDLE; all mem entries = 0.
  - busy = 0, done = 0, rd_data = 0, swap_cnt = 0.

## Timing
- Start sampled at edge k with len_q = N ≥ 2:
  - busy = 1 after edge k.
  - Compares occur at edges k+1 … k+C; DONE is entered at edge k+C, so done = 1 and busy = 0 during cycle k+C … k+C+1.
  - C ranges from N−1 (input already sorted) to N(N−1)/2 (worst case).
- len_q ≤ 1: done pulses after edge k; busy never rises; array unchanged.
- A new start is accepted from the cycle after done.
- rd_data latency: 1 cycle.

## Configuration
- SORT_STATS_EN defined: swap_cnt counts as described, is cleared at start, and holds its value after done until the next start or reset.
- SORT_STATS_EN undefined: the counter is not built and swap_cnt is tied to 0.
- Sort behaviour and timing are identical either way.

## Test plan
- Load {9,6,2,4}, len = 4, desc = 0 → array {2,4,6,9}; C = 6 compare cycles (3+2+1); swap_cnt = 5; done pulses once.
- Load {1,2,3,4,5,6,7,8}, len = 8, asc → unchanged; done after exactly 7 compare cycles; swap_cnt = 0.
- Load {3,1,5,1}, len = 4, desc = 1 → {5,3,1,1}; entries beyond len are untouched (preload index 4 = 0xAA and check it stays 0xAA).
- len = 0 and len = 1 → done after edge k, busy stays 0, array unchanged; len = DEPTH+5 → clamped to DEPTH and whole array sorted.
- During busy: wr_en to idx 0 with 0xFFFF and a second start → both ignored; result matches the no-disturb run.
- Drop rst_n mid-pass → busy/done/swap_cnt go to 0 immediately; every rd_addr reads 0; a fresh load and sort then completes correctly.
